qa_drv_rx_width_adapter: RTL and testbench



---
 rtl/qa_drv_rx_width_adapter.sv | 152 +++++++++++++++
 tb/tb_qa_drv_rx_width_adapter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qa_drv_rx_width_adapter.sv
// Host-channel receive width adapter: dequeues UMF_WIDTH chunks and re-emits them as
// OUT_WIDTH slices (LSB slice first). Optional counters built when QA_DRV_RX_ADAPTER_STATS_EN is defined.
module qa_drv_rx_width_adapter #(
    parameter int UMF_WIDTH = 128,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetb,
    input  logic [UMF_WIDTH-1:0] rx_fifo_data,
    input  logic                 rx_fifo_rdy,
    output logic                 rx_fifo_enable,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 out_rdy,
    input  logic                 out_enable,
    input  logic                 flush,
    output logic [31:0]          stat_chunks,
    output logic [31:0]          stat_stall_cycles
);

    localparam int RATIO = UMF_WIDTH / OUT_WIDTH;
    localparam int IDX_W = $clog2(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t               state_r, state_nxt_s;
    logic [IDX_W-1:0]     idx_r, idx_nxt_s;
    logic [UMF_WIDTH-1:0] active_r, active_nxt_s;
    logic [UMF_WIDTH-1:0] pf_r, pf_nxt_s;
    logic                 pf_valid_r, pf_valid_nxt_s;
    logic                 accept_s;
    logic                 fire_s;
    logic                 last_s;

    // Only the prefetch slot gates acceptance; a retiring active is refilled directly.
    assign accept_s       = resetb && rx_fifo_rdy && !flush && !pf_valid_r;
    assign fire_s         = out_enable && (state_r == ST_DRAIN);
    assign last_s         = (idx_r == LAST_IDX);
    assign rx_fifo_enable = accept_s;

    assign out_rdy  = (state_r == ST_DRAIN);
    assign out_last = last_s;
    assign out_data = active_r[int'(idx_r) * OUT_WIDTH +: OUT_WIDTH];

    // Next-state and buffer update logic
    always_comb begin
        state_nxt_s    = state_r;
        idx_nxt_s      = idx_r;
        active_nxt_s   = active_r;
        pf_nxt_s       = pf_r;
        pf_valid_nxt_s = pf_valid_r;
        if (flush) begin
            state_nxt_s    = ST_EMPTY;
            idx_nxt_s      = '0;
            pf_valid_nxt_s = 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s  = ST_DRAIN;
                        active_nxt_s = rx_fifo_data;
                        idx_nxt_s    = '0;
                    end else begin
                        state_nxt_s  = ST_EMPTY;
                    end
                end
                ST_DRAIN: begin
                    if (fire_s && last_s) begin
                        idx_nxt_s = '0;
                        if (pf_valid_r) begin
                            active_nxt_s   = pf_r;
                            pf_valid_nxt_s = 1'b0;
                        end else if (accept_s) begin
                            active_nxt_s   = rx_fifo_data;
                        end else begin
                            state_nxt_s    = ST_EMPTY;
                        end
                    end else begin
                        if (fire_s) begin
                            idx_nxt_s = idx_r + IDX_W'(1);
                        end else begin
                            idx_nxt_s = idx_r;
                        end
                        if (accept_s) begin
                            pf_nxt_s       = rx_fifo_data;
                            pf_valid_nxt_s = 1'b1;
                        end else begin
                            pf_valid_nxt_s = pf_valid_r;
                        end
                    end
                end
                default: begin
                    state_nxt_s    = ST_EMPTY;
                    idx_nxt_s      = '0;
                    pf_valid_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // State and buffer registers
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_r    <= ST_EMPTY;
            idx_r      <= '0;
            active_r   <= '0;
            pf_r       <= '0;
            pf_valid_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            idx_r      <= idx_nxt_s;
            active_r   <= active_nxt_s;
            pf_r       <= pf_nxt_s;
            pf_valid_r <= pf_valid_nxt_s;
        end
    end

`ifdef QA_DRV_RX_ADAPTER_STATS_EN
    logic [31:0] stat_chunks_r;
    logic [31:0] stat_stall_r;

    // Saturating chunk and stall counters; flush leaves them untouched
    always_ff @(posedge clk) begin
        if (!resetb) begin
            stat_chunks_r <= 32'd0;
            stat_stall_r  <= 32'd0;
        end else begin
            if (accept_s && (stat_chunks_r != 32'hFFFF_FFFF)) begin
                stat_chunks_r <= stat_chunks_r + 32'd1;
            end else begin
                stat_chunks_r <= stat_chunks_r;
            end
            if (out_rdy && !out_enable && (stat_stall_r != 32'hFFFF_FFFF)) begin
                stat_stall_r <= stat_stall_r + 32'd1;
            end else begin
                stat_stall_r <= stat_stall_r;
            end
        end
    end

    assign stat_chunks       = stat_chunks_r;
    assign stat_stall_cycles = stat_stall_r;
`else
    assign stat_chunks       = 32'd0;
    assign stat_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_qa_drv_rx_width_adapter.sv
// Self-checking bench for qa_drv_rx_width_adapter: directed scenarios plus randomized traffic
// compared every cycle against a queue-based model of the two-chunk buffer.
module tb_qa_drv_rx_width_adapter;

    localparam int UW = 128;
    localparam int OW = 32;
    localparam int R  = UW / OW;

    logic          clk = 1'b0;
    logic          resetb;
    logic [UW-1:0] rx_fifo_data;
    logic          rx_fifo_rdy;
    logic          rx_fifo_enable;
    logic [OW-1:0] out_data;
    logic          out_last;
    logic          out_rdy;
    logic          out_enable;
    logic          flush;
    logic [31:0]   stat_chunks;
    logic [31:0]   stat_stall_cycles;

    always #5 clk = ~clk;

    qa_drv_rx_width_adapter #(.UMF_WIDTH(UW), .OUT_WIDTH(OW)) dut (
        .clk              (clk),
        .resetb           (resetb),
        .rx_fifo_data     (rx_fifo_data),
        .rx_fifo_rdy      (rx_fifo_rdy),
        .rx_fifo_enable   (rx_fifo_enable),
        .out_data         (out_data),
        .out_last         (out_last),
        .out_rdy          (out_rdy),
        .out_enable       (out_enable),
        .flush            (flush),
        .stat_chunks      (stat_chunks),
        .stat_stall_cycles(stat_stall_cycles)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model: buffered chunks as a queue (at most two), slice index into the head chunk.
    logic [UW-1:0] mq[$];
    int            midx = 0;
    logic [31:0]   mchunks = 32'd0;
    logic [31:0]   mstall = 32'd0;
    bit            known = 1'b0;

    always @(posedge clk) begin
        bit exp_en;
        bit rdy_o;
        if (!resetb) begin
            mq.delete();
            midx    = 0;
            mchunks = 32'd0;
            mstall  = 32'd0;
            known   = 1'b1;
        end else if (known) begin
            exp_en = rx_fifo_rdy && !flush && (mq.size() < 2);
            rdy_o  = (mq.size() > 0);
            if (rdy_o && !out_enable && mstall != 32'hFFFF_FFFF) mstall = mstall + 32'd1;
            if (exp_en && mchunks != 32'hFFFF_FFFF) mchunks = mchunks + 32'd1;
            if (flush) begin
                mq.delete();
                midx = 0;
            end else begin
                if (rdy_o && out_enable) begin
                    midx++;
                    if (midx == R) begin
                        midx = 0;
                        void'(mq.pop_front());
                    end
                end
                if (exp_en) mq.push_back(rx_fifo_data);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic [UW-1:0] head;
        if (known) begin
            chk("out_rdy", out_rdy, (mq.size() > 0));
            chk("out_last", out_last, (midx == R - 1));
            if (mq.size() > 0) begin
                head = mq[0];
                chk("out_data", out_data, head[midx*OW +: OW]);
            end
            chk("rx_fifo_enable", rx_fifo_enable,
                resetb && rx_fifo_rdy && !flush && (mq.size() < 2));
`ifdef QA_DRV_RX_ADAPTER_STATS_EN
            chk("stat_chunks", stat_chunks, mchunks);
            chk("stat_stall", stat_stall_cycles, mstall);
`else
            chk("stat_chunks", stat_chunks, 32'd0);
            chk("stat_stall", stat_stall_cycles, 32'd0);
`endif
        end
    end

    // Source feeding the host-FIFO side; a chunk leaves only when dequeued.
    logic [UW-1:0] src[$];
    bit            feed_on = 1'b0;
    bit            took;
    int            enq_cnt = 0;

    task automatic tick();
        rx_fifo_rdy  = feed_on && (src.size() > 0);
        rx_fifo_data = rx_fifo_rdy ? src[0] : {$urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge clk);
        took = (rx_fifo_enable === 1'b1);
        @(posedge clk);
        #1;
        if (took && src.size() > 0) begin
            void'(src.pop_front());
            enq_cnt++;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [31:0] t1[4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    logic [31:0] c_before, s_before;
    int          e_before;

    initial begin
        resetb     = 1'b0;
        out_enable = 1'b0;
        flush      = 1'b0;
        rx_fifo_rdy  = 1'b0;
        rx_fifo_data = '0;
        ticks(2);
        resetb = 1'b1;
        chk("rst_out_rdy", out_rdy, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_stat_chunks", stat_chunks, 32'd0);
        chk("rst_stat_stall", stat_stall_cycles, 32'd0);

        // Single chunk split into four slices, LSB first
        e_before = enq_cnt;
        src.push_back(128'h44444444_33333333_22222222_11111111);
        feed_on    = 1'b1;
        out_enable = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("t1_rdy", out_rdy, 1'b1);
            chk("t1_data", out_data, t1[k]);
            chk("t1_last", out_last, (k == 3));
            tick();
        end
        chk("t1_empty", out_rdy, 1'b0);
        chk("t1_enq_once", enq_cnt - e_before, 1);

        // Three back-to-back chunks: 12 slices without a gap
        c_before = stat_chunks;
        for (int c = 0; c < 3; c++) src.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
        tick();
        for (int k = 0; k < 12; k++) begin
            chk("t2_no_gap", out_rdy, 1'b1);
            tick();
        end
        chk("t2_drained", out_rdy, 1'b0);
`ifdef QA_DRV_RX_ADAPTER_STATS_EN
        chk("t2_chunks", stat_chunks - c_before, 32'd3);
`else
        chk("t2_chunks", stat_chunks, 32'd0);
`endif

        // Two chunks held with no client dequeue for ten cycles
        s_before   = stat_stall_cycles;
        out_enable = 1'b0;
        src.push_back(128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0);
        src.push_back(128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0);
        src.push_back(128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0);
        ticks(11);
        chk("t3_hold_data", out_data, 32'hA0A0A0A0);
        chk("t3_third_not_taken", src.size(), 1);
`ifdef QA_DRV_RX_ADAPTER_STATS_EN
        chk("t3_stall", stat_stall_cycles - s_before, 32'd10);
`else
        chk("t3_stall", stat_stall_cycles, 32'd0);
`endif
        feed_on    = 1'b0;
        out_enable = 1'b1;
        ticks(8);
        chk("t3_drained", out_rdy, 1'b0);
        src.delete();

        // Flush after two slices of A with B prefetched; C must start clean
        src.push_back(128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0);
        src.push_back(128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0);
        src.push_back(128'hCCCC0003_CCCC0002_CCCC0001_CCCC0000);
        feed_on = 1'b1;
        ticks(3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_flushed", out_rdy, 1'b0);
        tick();
        chk("t4_c_rdy", out_rdy, 1'b1);
        chk("t4_c_slice0", out_data, 32'hCCCC0000);
        ticks(4);

        // Client dequeue with nothing buffered or offered
        feed_on  = 1'b0;
        c_before = stat_chunks;
        s_before = stat_stall_cycles;
        ticks(3);
        chk("t5_rdy", out_rdy, 1'b0);
        chk("t5_chunks", stat_chunks, c_before);
        chk("t5_stall", stat_stall_cycles, s_before);

        // Reset in the middle of a chunk
        src.push_back(128'hEEEE0003_EEEE0002_EEEE0001_EEEE0000);
        feed_on = 1'b1;
        ticks(2);
        resetb  = 1'b0;
        feed_on = 1'b0;
        tick();
        resetb = 1'b1;
        chk("t6_rdy", out_rdy, 1'b0);
        chk("t6_last", out_last, 1'b0);
        chk("t6_data", out_data, 32'd0);
        src.delete();
        src.push_back(128'hD0D00003_D0D00002_D0D00001_D0D00000);
        feed_on = 1'b1;
        tick();
        chk("t6_d_slice0", out_data, 32'hD0D00000);
        chk("t6_d_last", out_last, 1'b0);
        ticks(4);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            feed_on    = ($urandom_range(0, 3) != 0);
            out_enable = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 31) == 0);
            resetb     = ($urandom_range(0, 199) != 0);
            if (src.size() < 3) src.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
            tick();
        end
        resetb = 1'b1;
        flush  = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
